mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs, resolves the branch, and performs loads and stores against a variable-latency data memory through a req/ack handshake. While an access is in flight it stalls the upstream pipeline. Its results go into an internal MEM/WB register that feeds write-back.

## Interface
- `DATA_W`, default 32: data and address width.
- `TIMEOUT`, default 16: maximum number of ACCESS cycles to wait for `dmem_ack` before aborting.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hit`  in  1  the EX/MEM slot holds a valid instruction.
- `branchTarget`  in  DATA_W  branch destination.
- `zeroFlag`  in  1  ALU zero.
- `ALUResult`  in  DATA_W  memory address, or the ALU result to write back.
- `readData2`  in  DATA_W  store data.
- `writeReg`  in  5  destination register.
- `MemRead`, `MemWrite`, `Branch`, `RegWrite`, `MemToReg`  in  1 each  control bits.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  DATA_W  equals `ALUResult`.
- `dmem_wdata`  out  DATA_W  equals `readData2`.
- `dmem_ack`  in  1  access complete; read data valid in the same cycle.
- `dmem_rdata`  in  DATA_W  load data.
- `stall`  out  1  holds EX/MEM and all earlier stages.
- `PCSrc`  out  1  take the branch.
- `pcTarget`  out  DATA_W  equals `branchTarget`.
- `valid_Out`, `RegWrite_Out`, `MemToReg_Out`  out  1 each  MEM/WB control bits.
- `readData_Out`, `ALUResult_Out`  out  DATA_W  MEM/WB data.
- `writeReg_Out`  out  5  MEM/WB destination.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- `memop = hit & (MemRead | MemWrite)`.
- If `MemRead` and `MemWrite` are both set, the access is a write only. `RegWrite` still passes through unchanged.
- FSM states:
  - IDLE → ACCESS when `memop` is set.
  - ACCESS → IDLE when `dmem_ack` is set or the timeout counter equals `TIMEOUT`.
- `dmem_req = (IDLE & memop) | ACCESS`.
- `dmem_we = MemWrite`, driven combinationally from the held EX/MEM inputs.
- `stall = memop & ~(ACCESS & (dmem_ack | timeout))`.
- Timeout counter: 0 in IDLE, increments each ACCESS cycle without ack. Width is clog2(TIMEOUT+1). It never wraps.
- On a timeout:
  - the instruction retires with `RegWrite_Out = 0` and `valid_Out = 1`;
  - `mem_err` is set and stays set until reset.
- `dmem_ack` is ignored in IDLE. Ack is never accepted in the issue cycle.
- MEM/WB register capture, every clock edge:
  - `stall = 1`: captures a bubble (`valid_Out = 0`, `RegWrite_Out = 0`, `MemToReg_Out = 0`, data fields unchanged).
  - `hit = 0`: captures a bubble.
  - Otherwise captures `hit`, `RegWrite`, `MemToReg`, `ALUResult`, `writeReg`. `readData_Out` takes `dmem_rdata` for an acked read and 0 otherwise.
- `PCSrc = hit & Branch & zeroFlag`, combinational and independent of `stall`.

## Timing
- Reset values:
  - all outputs 0 (`dmem_req`, `stall`, `PCSrc`, `valid_Out`, `RegWrite_Out`, `MemToReg_Out`, `readData_Out`, `ALUResult_Out`, `writeReg_Out`, `mem_err`);
  - FSM in IDLE, counter 0.
- Non-memory instruction: zero stall. MEM/WB is updated at the first edge it is presented.
- Memory instruction issued in cycle T with ack in cycle T+n (n ≥ 1):
  - `stall` is high in cycles T through T+n−1.
  - MEM/WB captures the result at the end of cycle T+n, which is the same edge at which EX/MEM advances.
  - Minimum cost is one stall cycle.
- Timeout with no ack: MEM/WB captures at the end of cycle T+TIMEOUT.
- `dmem_addr`, `dmem_wdata` and `dmem_we` stay stable while `dmem_req` is high, because the upstream register is held.
- Reset asserted mid-access: `dmem_req` and `stall` drop immediately (asynchronous). An ack arriving after reset is ignored.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum (IDLE, ACCESS);
  - the width constants for the data path and the 5-bit register index.
- One sub-module, `mem_wb_reg`: the MEM/WB pipeline register with bubble insert and async reset.
- The FSM, handshake and branch logic live in `mem_stage`.

## Test plan
- Reset: hold `rst_n = 0` with random inputs → every output 0. Release → no `dmem_req` while `hit = 0`.
- ALU op: `hit = 1`, `RegWrite = 1`, `ALUResult = 32'h5`, `writeReg = 3` → no stall; after one edge `valid_Out = 1`, `ALUResult_Out = 5`, `writeReg_Out = 3`.
- Load with ack after 3 cycles, `dmem_rdata = 32'hCAFE` → `stall` high for 3 cycles; `readData_Out = 32'hCAFE`, `MemToReg_Out = 1`; bubbles captured during the stall.
- Store with `MemRead = MemWrite = 1` → `dmem_we = 1`, `dmem_wdata = readData2`, `readData_Out = 0` after ack.
- No ack, `TIMEOUT = 16` → stall for 16 cycles, `RegWrite_Out = 0`, `mem_err = 1` and still 1 after later normal instructions.
- Branch: `hit = 1`, `Branch = 1`, `zeroFlag = 1` → `PCSrc = 1` in the same cycle, `pcTarget = branchTarget`. With `hit = 0` → `PCSrc = 0`. Reset during ACCESS → `dmem_req = 0` immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Shared types and widths for the MIPS pipeline stages.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_REG_W  = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memState_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// +----------------------------------------------------------------------+
// | mem_wb_reg                                                           |
// | MEM/WB pipeline register with bubble insertion and async reset.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int REG_W  = c_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic              i_regWrite,
  input  logic              i_memToReg,
  input  logic [DATA_W-1:0] i_readData,
  input  logic [DATA_W-1:0] i_aluResult,
  input  logic [REG_W-1:0]  i_writeReg,
  output logic              o_valid,
  output logic              o_regWrite,
  output logic              o_memToReg,
  output logic [DATA_W-1:0] o_readData,
  output logic [DATA_W-1:0] o_aluResult,
  output logic [REG_W-1:0]  o_writeReg
);

  logic              r_valid;
  logic              r_regWrite;
  logic              r_memToReg;
  logic [DATA_W-1:0] r_readData;
  logic [DATA_W-1:0] r_aluResult;
  logic [REG_W-1:0]  r_writeReg;

  // A bubble clears only the control bits; data fields keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_memToReg  <= 1'b0;
      r_readData  <= '0;
      r_aluResult <= '0;
      r_writeReg  <= '0;
    end else if (i_bubble) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
    end else begin
      r_valid     <= i_valid;
      r_regWrite  <= i_regWrite;
      r_memToReg  <= i_memToReg;
      r_readData  <= i_readData;
      r_aluResult <= i_aluResult;
      r_writeReg  <= i_writeReg;
    end
  end

  assign o_valid     = r_valid;
  assign o_regWrite  = r_regWrite;
  assign o_memToReg  = r_memToReg;
  assign o_readData  = r_readData;
  assign o_aluResult = r_aluResult;
  assign o_writeReg  = r_writeReg;

endmodule : mem_wb_reg

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------+
// | mem_stage                                                            |
// | MIPS memory stage: branch resolve, req/ack data access, MEM/WB reg.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hit,
  input  logic [DATA_W-1:0]  branchTarget,
  input  logic               zeroFlag,
  input  logic [DATA_W-1:0]  ALUResult,
  input  logic [DATA_W-1:0]  readData2,
  input  logic [c_REG_W-1:0] writeReg,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               Branch,
  input  logic               RegWrite,
  input  logic               MemToReg,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               stall,
  output logic               PCSrc,
  output logic [DATA_W-1:0]  pcTarget,
  output logic               valid_Out,
  output logic               RegWrite_Out,
  output logic               MemToReg_Out,
  output logic [DATA_W-1:0]  readData_Out,
  output logic [DATA_W-1:0]  ALUResult_Out,
  output logic [c_REG_W-1:0] writeReg_Out,
  output logic               mem_err
);

  localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  memState_t          r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_memErr;

  logic               w_memop;
  logic               w_inAccess;
  logic               w_ack;
  logic               w_limit;
  logic               w_timeout;
  logic               w_stall;
  logic               w_bubble;
  logic [DATA_W-1:0]  w_readData;

  assign w_memop    = hit & (MemRead | MemWrite);
  assign w_inAccess = (r_state == ACCESS);
  assign w_ack      = w_inAccess & dmem_ack;
  assign w_limit    = w_inAccess & (r_cnt == c_TIMEOUT);
  // An ack arriving on the limit cycle still completes the access normally.
  assign w_timeout  = w_limit & ~dmem_ack;
  assign w_stall    = w_memop & ~(w_ack | w_limit);

  // The issue cycle counts as the first wait cycle, so the counter enters
  // ACCESS at 1 and the limit cycle is T+TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_memErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_memop) begin
            r_state <= ACCESS;
            r_cnt   <= c_ONE;
          end
        end
        ACCESS: begin
          if (dmem_ack || w_limit) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
          if (w_timeout) begin
            r_memErr <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Gated by rst_n so the request and stall drop the moment reset asserts.
  assign dmem_req   = rst_n & (((r_state == IDLE) & w_memop) | w_inAccess);
  assign stall      = rst_n & w_stall;
  assign dmem_we    = MemWrite;
  assign dmem_addr  = ALUResult;
  assign dmem_wdata = readData2;
  assign PCSrc      = rst_n & hit & Branch & zeroFlag;
  assign pcTarget   = branchTarget;
  assign mem_err    = r_memErr;

  assign w_bubble   = w_stall | ~hit;
  assign w_readData = (w_ack & MemRead & ~MemWrite) ? dmem_rdata : '0;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (c_REG_W)
  ) u_memWb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_bubble    (w_bubble),
    .i_valid     (hit),
    .i_regWrite  (RegWrite & ~w_timeout),
    .i_memToReg  (MemToReg),
    .i_readData  (w_readData),
    .i_aluResult (ALUResult),
    .i_writeReg  (writeReg),
    .o_valid     (valid_Out),
    .o_regWrite  (RegWrite_Out),
    .o_memToReg  (MemToReg_Out),
    .o_readData  (readData_Out),
    .o_aluResult (ALUResult_Out),
    .o_writeReg  (writeReg_Out)
  );

endmodule : mem_stage

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +----------------------------------------------------------------------+
// | tb_mem_stage                                                         |
// | Directed self-checking bench for mem_stage.                          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hit;
  logic [31:0] branchTarget;
  logic        zeroFlag;
  logic [31:0] ALUResult;
  logic [31:0] readData2;
  logic [4:0]  writeReg;
  logic        MemRead, MemWrite, Branch, RegWrite, MemToReg;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, PCSrc;
  logic [31:0] pcTarget;
  logic        valid_Out, RegWrite_Out, MemToReg_Out;
  logic [31:0] readData_Out, ALUResult_Out;
  logic [4:0]  writeReg_Out;
  logic        mem_err;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .branchTarget(branchTarget),
    .zeroFlag(zeroFlag), .ALUResult(ALUResult), .readData2(readData2),
    .writeReg(writeReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .PCSrc(PCSrc), .pcTarget(pcTarget),
    .valid_Out(valid_Out), .RegWrite_Out(RegWrite_Out),
    .MemToReg_Out(MemToReg_Out), .readData_Out(readData_Out),
    .ALUResult_Out(ALUResult_Out), .writeReg_Out(writeReg_Out),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hit = 0; branchTarget = 0; zeroFlag = 0; ALUResult = 0; readData2 = 0;
    writeReg = 0; MemRead = 0; MemWrite = 0; Branch = 0; RegWrite = 0;
    MemToReg = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, "_req"},   32'(dmem_req), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_pcsrc"}, 32'(PCSrc), 0);
    chk({tag, "_valid"}, 32'(valid_Out), 0);
    chk({tag, "_rw"},    32'(RegWrite_Out), 0);
    chk({tag, "_m2r"},   32'(MemToReg_Out), 0);
    chk({tag, "_rdata"}, readData_Out, 0);
    chk({tag, "_alu"},   ALUResult_Out, 0);
    chk({tag, "_wreg"},  32'(writeReg_Out), 0);
    chk({tag, "_err"},   32'(mem_err), 0);
  endtask

  initial begin
    int n;
    // Reset with random inputs
    rst_n = 0;
    hit = 1; MemRead = 1; Branch = 1; zeroFlag = 1;
    MemWrite = 1'($urandom); RegWrite = 1'($urandom); MemToReg = 1'($urandom);
    branchTarget = $urandom; ALUResult = $urandom; readData2 = $urandom;
    writeReg = 5'($urandom); dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #2;
    chkResetOuts("rst0");
    tick(); tick();
    chkResetOuts("rst1");
    clr();
    MemRead = 1;
    rst_n = 1;
    #1;
    chk("idle_nohit_req", 32'(dmem_req), 0);
    tick();
    chk("idle_nohit_req2", 32'(dmem_req), 0);
    chk("idle_nohit_valid", 32'(valid_Out), 0);

    // ALU op
    clr(); hit = 1; RegWrite = 1; ALUResult = 32'h5; writeReg = 5'd3;
    #1;
    chk("alu_stall", 32'(stall), 0);
    chk("alu_req", 32'(dmem_req), 0);
    tick();
    chk("alu_valid", 32'(valid_Out), 1);
    chk("alu_rw", 32'(RegWrite_Out), 1);
    chk("alu_res", ALUResult_Out, 32'h5);
    chk("alu_wreg", 32'(writeReg_Out), 3);
    chk("alu_rdata", readData_Out, 0);

    // Load, ack in T+3
    clr(); hit = 1; MemRead = 1; MemToReg = 1; RegWrite = 1;
    ALUResult = 32'h100; writeReg = 5'd7;
    #1;
    chk("ld_T_stall", 32'(stall), 1);
    chk("ld_T_req", 32'(dmem_req), 1);
    chk("ld_T_we", 32'(dmem_we), 0);
    chk("ld_T_addr", dmem_addr, 32'h100);
    tick();
    chk("ld_T1_stall", 32'(stall), 1);
    chk("ld_T1_bubble", 32'(valid_Out), 0);
    tick();
    chk("ld_T2_stall", 32'(stall), 1);
    chk("ld_T2_bubble", 32'(valid_Out), 0);
    chk("ld_T2_addr", dmem_addr, 32'h100);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hCAFE;
    #1;
    chk("ld_T3_stall", 32'(stall), 0);
    chk("ld_T3_req", 32'(dmem_req), 1);
    tick();
    chk("ld_valid", 32'(valid_Out), 1);
    chk("ld_rdata", readData_Out, 32'hCAFE);
    chk("ld_m2r", 32'(MemToReg_Out), 1);
    chk("ld_rw", 32'(RegWrite_Out), 1);
    chk("ld_wreg", 32'(writeReg_Out), 7);
    clr();
    #1;
    chk("ld_after_req", 32'(dmem_req), 0);

    // Store with MemRead=MemWrite=1; ack in the issue cycle must be ignored
    clr(); hit = 1; MemRead = 1; MemWrite = 1; RegWrite = 1;
    ALUResult = 32'h200; readData2 = 32'hDEADBEEF; writeReg = 5'd9;
    dmem_ack = 1; dmem_rdata = 32'h1234;
    #1;
    chk("st_T_we", 32'(dmem_we), 1);
    chk("st_T_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("st_T_ackign", 32'(stall), 1);
    tick();
    chk("st_T1_bubble", 32'(valid_Out), 0);
    chk("st_T1_stall", 32'(stall), 0);
    tick();
    chk("st_valid", 32'(valid_Out), 1);
    chk("st_rdata", readData_Out, 0);
    chk("st_rw", 32'(RegWrite_Out), 1);
    chk("st_err", 32'(mem_err), 0);

    // Timeout: no ack
    clr(); hit = 1; MemRead = 1; RegWrite = 1; MemToReg = 1;
    ALUResult = 32'h300; writeReg = 5'd4;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
    end
    chk("to_stallcycles", n, 16);
    chk("to_err_pre", 32'(mem_err), 0);
    tick();
    chk("to_valid", 32'(valid_Out), 1);
    chk("to_rw", 32'(RegWrite_Out), 0);
    chk("to_err", 32'(mem_err), 1);
    clr(); hit = 1; RegWrite = 1; ALUResult = 32'h77; writeReg = 5'd2;
    tick();
    chk("post_to_rw", 32'(RegWrite_Out), 1);
    chk("post_to_alu", ALUResult_Out, 32'h77);
    chk("post_to_err", 32'(mem_err), 1);

    // Branch
    clr(); hit = 1; Branch = 1; zeroFlag = 1; branchTarget = 32'hABCD;
    #1;
    chk("br_pcsrc", 32'(PCSrc), 1);
    chk("br_target", pcTarget, 32'hABCD);
    zeroFlag = 0;
    #1;
    chk("br_nz_pcsrc", 32'(PCSrc), 0);
    zeroFlag = 1; hit = 0;
    #1;
    chk("br_nohit_pcsrc", 32'(PCSrc), 0);
    tick();

    // Reset during ACCESS
    clr(); hit = 1; MemRead = 1; ALUResult = 32'h400;
    tick();
    chk("rsta_req", 32'(dmem_req), 1);
    #2;
    rst_n = 0;
    #1;
    chk("rsta_req_drop", 32'(dmem_req), 0);
    chk("rsta_stall_drop", 32'(stall), 0);
    chk("rsta_err", 32'(mem_err), 0);
    dmem_ack = 1; dmem_rdata = 32'h5555;
    tick();
    rst_n = 1;
    #1;
    chk("rsta_ackign", 32'(stall), 1);
    chk("rsta_valid", 32'(valid_Out), 0);
    tick();
    #1;
    chk("rsta_access_ack", 32'(stall), 0);
    tick();
    chk("rsta_done_valid", 32'(valid_Out), 1);
    chk("rsta_done_rdata", readData_Out, 32'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule : tb_mem_stage

`default_nettype wire
